// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request definitions: packet layout, arbitration modes and a
// one-hot to index helper used by the arbiter and its grant path.
package l2_request_arbiter_pkg;

  localparam int CORE_W  = 4;
  localparam int OP_W    = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_SRC = 8;

  typedef enum logic [0:0] {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED       = 1'b1
  } arb_mode_t;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] core;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } l2req_packet_t;

  // OR of the indices of all set bits; exact for one-hot or zero inputs.
  function automatic logic [2:0] oh_to_idx(input logic [MAX_SRC-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Single-grant arbiter: round-robin from an internal pointer, or fixed
// priority (index 0 highest) when the pointer is held at zero.
module rr_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int        N     = 3,
  parameter arb_mode_t MODE  = ARB_ROUND_ROBIN,
  localparam int       PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [N-1:0]       upper_mask;
  logic [N-1:0]       masked_req;
  logic [N-1:0]       sel_req;
  logic [MAX_SRC-1:0] grant_ext;

  // Requests at or above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    upper_mask = ~((N'(1) << ptr) - N'(1));
    masked_req = req & upper_mask;
    sel_req    = (|masked_req) ? masked_req : req;
    grant      = en ? (sel_req & (~sel_req + N'(1))) : '0;
  end

  always_comb begin
    grant_ext          = '0;
    grant_ext[N-1:0]   = grant;
    if (int'(oh_to_idx(grant_ext)) + 1 >= N) begin
      ptr_next = '0;
    end else begin
      ptr_next = PTR_W'(int'(oh_to_idx(grant_ext)) + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (MODE == ARB_ROUND_ROBIN && |grant) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Arbitrates L1 miss/store sources onto a single registered L2 request slot,
// tracking per-source outstanding requests against a credit limit.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int        CORE_ID         = 0,
  parameter int        NUM_SOURCES     = 3,
  parameter int        MAX_OUTSTANDING = 4,
  parameter arb_mode_t ARB_MODE        = ARB_ROUND_ROBIN,
  localparam int       IDX_W           = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
  localparam int       CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic          [NUM_SOURCES-1:0]     src_request_valid,
  input  l2req_packet_t [NUM_SOURCES-1:0]     src_request,
  output logic          [NUM_SOURCES-1:0]     src_ack,
  output l2req_packet_t                       l2i_request,
  input  logic                                l2_ready,
  input  logic                                rsp_done_en,
  input  logic          [IDX_W-1:0]           rsp_done_src,
  output logic          [NUM_SOURCES-1:0]     src_idle
);

  // Handshake: a source's packet is taken in the cycle src_ack is high; the
  // L2 takes l2i_request at an edge where l2i_request.valid and l2_ready are
  // both high, and l2i_request is held unchanged while valid without ready.

  logic [CNT_W-1:0]       outstanding [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] credit;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] grant;
  logic [MAX_SRC-1:0]     grant_ext;
  logic [IDX_W-1:0]       grant_idx;
  logic                   slot_free;
  logic                   arb_en;
  logic                   rsp_in_range;
  l2req_packet_t          load_pkt;

  assign slot_free    = !l2i_request.valid || l2_ready;
  assign arb_en       = slot_free && !reset;
  assign rsp_in_range = (int'(rsp_done_src) < NUM_SOURCES);

  // A retiring credit counts immediately, so a full source can be re-granted
  // in the very cycle its response comes back.
  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      credit[i]   = rsp_done_en && rsp_in_range &&
                    (rsp_done_src == IDX_W'(i)) && (outstanding[i] != '0);
      eligible[i] = src_request_valid[i] &&
                    ((outstanding[i] < CNT_W'(MAX_OUTSTANDING)) || credit[i]);
      src_idle[i] = (outstanding[i] == '0);
    end
  end

  rr_arbiter #(
    .N    (NUM_SOURCES),
    .MODE (ARB_MODE)
  ) u_rr_arbiter (
    .clk   (clk),
    .reset (reset),
    .req   (eligible),
    .en    (arb_en),
    .grant (grant)
  );

  assign src_ack = grant;

  always_comb begin
    grant_ext                  = '0;
    grant_ext[NUM_SOURCES-1:0] = grant;
    grant_idx                  = IDX_W'(oh_to_idx(grant_ext));
    load_pkt                   = src_request[grant_idx];
    load_pkt.valid             = 1'b1;
    load_pkt.core              = CORE_W'(CORE_ID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l2i_request <= '0;
    end else if (slot_free) begin
      if (|grant) begin
        l2i_request <= load_pkt;
      end else if (l2_ready) begin
        l2i_request.valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SOURCES; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (grant[i] && !credit[i]) begin
          outstanding[i] <= outstanding[i] + CNT_W'(1);
        end else if (!grant[i] && credit[i]) begin
          outstanding[i] <= outstanding[i] - CNT_W'(1);
        end
      end
    end
  end

  // A retire for an idle or nonexistent source is a protocol error upstream.
  a_rsp_valid : assert property (@(posedge clk) disable iff (reset)
    rsp_done_en |-> |credit);

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: a round-robin and a fixed-priority instance,
// a cycle-level reference model, and directed scenarios with literal checks.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int NS   = 3;
  localparam int MAXO = 4;
  localparam int CID0 = 5;
  localparam int CID1 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NS-1:0]          vld  [2];
  l2req_packet_t [NS-1:0] pkt  [2];
  logic                   rdy  [2];
  logic                   ren  [2];
  logic [1:0]             rsrc [2];
  logic [NS-1:0]          ack  [2];
  logic [NS-1:0]          idle [2];
  l2req_packet_t          l2i  [2];

  l2_request_arbiter #(
    .CORE_ID(CID0), .NUM_SOURCES(NS), .MAX_OUTSTANDING(MAXO), .ARB_MODE(ARB_ROUND_ROBIN)
  ) dut_rr (
    .clk(clk), .reset(reset), .src_request_valid(vld[0]), .src_request(pkt[0]),
    .src_ack(ack[0]), .l2i_request(l2i[0]), .l2_ready(rdy[0]),
    .rsp_done_en(ren[0]), .rsp_done_src(rsrc[0]), .src_idle(idle[0])
  );

  l2_request_arbiter #(
    .CORE_ID(CID1), .NUM_SOURCES(NS), .MAX_OUTSTANDING(MAXO), .ARB_MODE(ARB_FIXED)
  ) dut_fx (
    .clk(clk), .reset(reset), .src_request_valid(vld[1]), .src_request(pkt[1]),
    .src_ack(ack[1]), .l2i_request(l2i[1]), .l2_ready(rdy[1]),
    .rsp_done_en(ren[1]), .rsp_done_src(rsrc[1]), .src_idle(idle[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [NS-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_cnt [2][NS];
  int            m_ptr [2];
  l2req_packet_t m_reg [2];
  int            n_cnt [2][NS];
  int            n_ptr [2];
  l2req_packet_t n_reg [2];

  task automatic model_eval(input int m);
    logic [NS-1:0] exp_ack, exp_idle;
    bit            free;
    bit            cred [NS];
    bit            elig [NS];
    int            g, s;
    exp_ack  = '0;
    exp_idle = '0;
    if (reset) begin
      exp_idle = '1;
      check($sformatf("m%0d_ack", m), ack[m], exp_ack);
      check($sformatf("m%0d_idle", m), idle[m], exp_idle);
      check($sformatf("m%0d_req", m), l2i[m], '0);
      for (int i = 0; i < NS; i++) n_cnt[m][i] = 0;
      n_ptr[m] = 0;
      n_reg[m] = '0;
      return;
    end
    free = !m_reg[m].valid || rdy[m];
    for (int i = 0; i < NS; i++) begin
      cred[i] = ren[m] && (int'(rsrc[m]) == i) && (m_cnt[m][i] > 0);
      elig[i] = vld[m][i] && ((m_cnt[m][i] < MAXO) || cred[i]);
      exp_idle[i] = (m_cnt[m][i] == 0);
    end
    g = -1;
    if (free) begin
      for (int k = 0; k < NS; k++) begin
        s = (m == 1) ? k : (m_ptr[m] + k) % NS;
        if (g < 0 && elig[s]) g = s;
      end
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    check($sformatf("m%0d_ack", m), ack[m], exp_ack);
    check($sformatf("m%0d_idle", m), idle[m], exp_idle);
    check($sformatf("m%0d_req", m), l2i[m], m_reg[m]);
    for (int i = 0; i < NS; i++)
      n_cnt[m][i] = m_cnt[m][i] + ((g == i) ? 1 : 0) - (cred[i] ? 1 : 0);
    n_ptr[m] = (m == 0 && g >= 0) ? (g + 1) % NS : m_ptr[m];
    n_reg[m] = m_reg[m];
    if (free) begin
      if (g >= 0) begin
        n_reg[m]       = pkt[m][g];
        n_reg[m].valid = 1'b1;
        n_reg[m].core  = (m == 0) ? 4'(CID0) : 4'(CID1);
      end else if (rdy[m]) begin
        n_reg[m].valid = 1'b0;
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NS; i++) m_cnt[m][i] = 0;
      m_ptr[m] = 0;
      m_reg[m] = '0;
    end
    forever begin
      @(negedge clk);
      model_eval(0);
      model_eval(1);
      @(posedge clk);
      m_cnt = n_cnt;
      m_ptr = n_ptr;
      m_reg = n_reg;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input int m, input int src, input int times);
    for (int k = 0; k < times; k++) begin
      ren[m]  = 1'b1;
      rsrc[m] = 2'(src);
      cyc();
    end
    ren[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  l2req_packet_t exp_b;

  initial begin
    for (int m = 0; m < 2; m++) begin
      vld[m] = '0; rdy[m] = 1'b0; ren[m] = 1'b0; rsrc[m] = '0;
      for (int s = 0; s < NS; s++)
        pkt[m][s] = '{valid: 1'b1, core: 4'hF, op: 3'(s + 1),
                      addr: 32'hA000_0000 + 32'(m * 16 + s), data: 32'hD000_0000 + 32'(s)};
    end
    exp_b = '{valid: 1'b1, core: 4'd5, op: 3'd2, addr: 32'hA000_0001, data: 32'hD000_0001};

    // Reset state
    cyc(); cyc();
    @(negedge clk);
    check("rst_ack", ack[0], 3'b000);
    check("rst_idle", idle[0], 3'b111);
    check("rst_req", l2i[0], '0);
    cyc();
    reset = 1'b0;

    // A: round-robin, all valid, ready high
    vld[0] = 3'b111; rdy[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b100);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("A_ack", ack[0], exp_q.pop_front());
      if (k > 0) check("A_core", l2i[0].core, 4'd5);
      cyc();
    end
    vld[0] = '0;
    cyc();
    for (int s = 0; s < NS; s++) retire(0, s, 2);
    @(negedge clk);
    check("A_idle", idle[0], 3'b111);
    cyc();

    // B: source 1 held against a stalled L2
    vld[0] = 3'b010; rdy[0] = 1'b0;
    @(negedge clk);
    check("B_ack", ack[0], 3'b010);
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("B_hold_ack", ack[0], 3'b000);
      check("B_hold_req", l2i[0], exp_b);
      cyc();
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    check("B_reack", ack[0], 3'b010);
    cyc();
    vld[0] = '0;
    cyc();
    retire(0, 1, 2);

    // C: source 0 saturates at four, a credit re-opens it in the same cycle
    vld[0] = 3'b001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("C_ack", ack[0], (k < 4) ? 3'b001 : 3'b000);
      cyc();
    end
    ren[0] = 1'b1; rsrc[0] = 2'd0;
    @(negedge clk);
    check("C_credit_ack", ack[0], 3'b001);
    cyc();
    ren[0] = 1'b0;
    @(negedge clk);
    check("C_sat_again", ack[0], 3'b000);
    cyc();
    vld[0] = '0;
    retire(0, 0, 4);

    // D: ack and retire on source 2 together while it holds three
    vld[0] = 3'b100;
    cyc(); cyc(); cyc();
    ren[0] = 1'b1; rsrc[0] = 2'd2;
    @(negedge clk);
    check("D_ack", ack[0], 3'b100);
    cyc();
    ren[0] = 1'b0; vld[0] = '0;
    @(negedge clk);
    check("D_idle", idle[0], 3'b011);
    cyc();
    vld[0] = 3'b100;
    @(negedge clk);
    check("D_fourth", ack[0], 3'b100);
    cyc();
    @(negedge clk);
    check("D_sat", ack[0], 3'b000);
    cyc();

    // E: reset while a request is held and counters are nonzero
    vld[0] = 3'b011; rdy[0] = 1'b0;
    cyc();
    vld[0] = 3'b111;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("E_valid", l2i[0].valid, 1'b0);
    check("E_idle", idle[0], 3'b111);
    check("E_ack", ack[0], 3'b000);
    cyc();
    reset = 1'b0; rdy[0] = 1'b1;
    @(negedge clk);
    check("E_first", ack[0], 3'b001);
    cyc();
    @(negedge clk);
    check("E_second", ack[0], 3'b010);
    cyc();
    vld[0] = '0; rdy[0] = 1'b0;
    cyc();
    retire(0, 0, 1);
    retire(0, 1, 1);

    // F: fixed priority, sources 0 and 2
    vld[1] = 3'b101; rdy[1] = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(3'b001);
    for (int k = 0; k < 4; k++) exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("F_ack", ack[1], exp_q.pop_front());
      if (k > 0) check("F_core", l2i[1].core, 4'd2);
      cyc();
    end
    vld[1] = '0;
    retire(1, 0, 4);
    retire(1, 2, 4);
    @(negedge clk);
    check("F_idle", idle[1], 3'b111);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

Interface
REQ-001 SHALL have parameter CORE_ID, default 0: core index stamped into every outgoing request.
REQ-002 SHALL have parameter NUM_SOURCES, default 3: number of L1 miss/store sources, range 1..8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: per-source in-flight request limit, range 1..15.
REQ-004 SHALL have parameter ARB_MODE, default ARB_ROUND_ROBIN: ARB_ROUND_ROBIN or ARB_FIXED (index 0 highest priority).
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port src_request_valid, input, NUM_SOURCES: per-source request pending.
REQ-008 SHALL have port src_request, input, NUM_SOURCES x l2req_packet_t: per-source packet; core and valid fields ignored.
REQ-009 SHALL have port src_ack, output, NUM_SOURCES: one-hot/zero; source packet accepted this cycle.
REQ-010 SHALL have port l2i_request, output, l2req_packet_t: registered request to L2.
REQ-011 SHALL have port l2_ready, input, 1: L2 accepts l2i_request at this edge.
REQ-012 SHALL have port rsp_done_en, input, 1: response for one source retired this cycle.
REQ-013 SHALL have port rsp_done_src, input, $clog2(NUM_SOURCES) (min 1): source of retired response.
REQ-014 SHALL have port src_idle, output, NUM_SOURCES: source has zero outstanding requests (for membar/flush drain).

Function
REQ-015 SHALL hold l2i_request (all fields) stable while l2i_request.valid=1 and l2_ready=0.
REQ-016 SHALL treat the output slot as free when l2i_request.valid=0 or l2_ready=1 (same-cycle drain and refill allowed, full throughput one request per cycle).
REQ-017 SHALL make source i eligible when src_request_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-018 SHALL assert src_ack for exactly one eligible source when the slot is free and any source is eligible, combinationally in the same cycle.
REQ-019 SHALL, in ARB_FIXED, grant the lowest-index eligible source.
REQ-020 SHALL, in ARB_ROUND_ROBIN, search from rr_ptr upward modulo NUM_SOURCES and set rr_ptr to (granted index + 1) mod NUM_SOURCES at the edge; rr_ptr unchanged when no grant.
REQ-021 SHALL load the granted packet into l2i_request at the edge after src_ack, with valid=1 and core=CORE_ID (latency 1 cycle request-to-output).
REQ-022 SHALL clear l2i_request.valid at the edge when l2_ready=1 and no grant occurs.
REQ-023 SHALL keep a counter outstanding[i] of width $clog2(MAX_OUTSTANDING+1): +1 on src_ack[i], -1 on rsp_done_en with rsp_done_src=i, unchanged when both occur in the same cycle.
REQ-024 SHALL assert (simulation) on rsp_done_en to a source with outstanding=0 or rsp_done_src >= NUM_SOURCES, leaving counters unchanged.
REQ-025 SHALL compute src_idle[i] = (outstanding[i]==0) combinationally from registered counters.
REQ-026 SHALL count a request as outstanding from src_ack, not from l2_ready; a credit returned in the same cycle as a full counter makes the source eligible in that same cycle.

Reset
REQ-027 SHALL, on reset, clear l2i_request to all-zero, all outstanding counters to 0, rr_ptr to 0; src_ack=0 and src_idle all-ones while reset asserted.
REQ-028 SHALL discard any held or in-flight request state on reset mid-operation; no src_ack during reset.

Structure
REQ-029 SHALL place arb_mode_t (ARB_ROUND_ROBIN, ARB_FIXED) in the shared defines package beside l2req_packet_t.
REQ-030 SHALL implement grant selection in one sub-module, rr_arbiter (request vector, enable, one-hot grant, internal pointer).
REQ-031 SHALL reuse oh_to_idx for grant-to-index conversion.

Verification
REQ-032 SHALL cover: NUM_SOURCES=3 round-robin, all valid continuously, l2_ready=1 -> grants 0,1,2,0,1,2 one per cycle; l2i_request.core=CORE_ID.
REQ-033 SHALL cover: src 1 valid, l2_ready=0 for 5 cycles -> l2i_request constant 5 cycles, src_ack[1] once, no further ack until l2_ready=1.
REQ-034 SHALL cover: MAX_OUTSTANDING=4, src 0 only, no responses -> exactly 4 acks, then stall; one rsp_done_src=0 -> fifth ack same cycle.
REQ-035 SHALL cover: ARB_FIXED, sources 0 and 2 valid -> source 0 granted every cycle until it saturates at 4, then source 2 granted.
REQ-036 SHALL cover: src_ack[2] and rsp_done_src=2 same cycle with outstanding[2]=3 -> stays 3; src_idle[2]=0.
REQ-037 SHALL cover: reset asserted while valid request held and counters nonzero -> l2i_request.valid=0, src_idle=3'b111 immediately, rr_ptr restarts at source 0.
